// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: burst codes,
// burst-length decode and the arbiter FSM state encoding.
package mem_pkg;

  // Burst codes presented on i_acc_size / d_acc_size
  localparam logic [1:0] BURST_1  = 2'b00;
  localparam logic [1:0] BURST_4  = 2'b01;
  localparam logic [1:0] BURST_8  = 2'b10;
  localparam logic [1:0] BURST_16 = 2'b11;

  // Beat counter width; holds a beat count of up to 16
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10,
    DRAIN   = 2'b11
  } arb_state_t;

  // Number of beats in a burst for a given burst code
  function automatic logic [CNT_W-1:0] burst_len(input logic [1:0] code);
    case (code)
      BURST_1: return 5'd1;
      BURST_4: return 5'd4;
      BURST_8: return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_burst_ctr.sv
// Beat counter and word-address incrementer for one burst. Loaded at grant,
// advanced once per accepted beat; 'last' flags the final beat of the burst.
module mem_burst_ctr
  import mem_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [ADDRESS_SIZE-1:0] start_addr,
  input  logic [CNT_W-1:0]        len,
  input  logic                    adv,
  output logic [ADDRESS_SIZE-1:0] addr,
  output logic                    last
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;

  // Capture burst at grant, then step address by one word per accepted beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= start_addr;
      cnt   <= '0;
      len_q <= len;
    end else if (adv) begin
      addr  <= addr + ADDRESS_SIZE'(4);
      cnt   <= cnt + 5'd1;
    end
  end

  // cnt counts beats already accepted, so the last beat is at len-1
  assign last = (cnt == len_q - 5'd1);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) burst arbiter in front of a single-ported memory.
// Round-robin on ties, one burst at a time, one-cycle DRAIN after each burst.
// Optional feature: define MEM_ARB_WATCHDOG_EN to abort bursts stalled by
// mem_busy for WD_LIMIT consecutive cycles and raise a sticky err.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int ACCESS_SIZE  = 2,
  parameter int WD_LIMIT     = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  input  logic [ACCESS_SIZE-1:0]  i_acc_size,
  output logic                    i_beat,
  output logic                    i_rvalid,
  output logic                    i_done,
  input  logic                    d_req,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [ACCESS_SIZE-1:0]  d_acc_size,
  input  logic                    d_wren,
  input  logic [DATA_SIZE-1:0]    d_wdata,
  output logic                    d_beat,
  output logic                    d_rvalid,
  output logic                    d_done,
  output logic [DATA_SIZE-1:0]    rdata,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  output logic                    mem_wren,
  output logic                    mem_en,
  input  logic                    mem_busy,
  output logic                    err
);

  arb_state_t              state;
  logic                    last_d;     // 1: data port held the most recent grant
  logic                    wren_q;     // store burst in progress
  logic                    load;
  logic                    pick_d;
  logic                    in_grant;
  logic                    beat;
  logic                    stall;
  logic                    last;
  logic                    wd_trip;
  logic [ADDRESS_SIZE-1:0] cur_addr;
  logic [ADDRESS_SIZE-1:0] start_addr;
  logic [CNT_W-1:0]        start_len;

  assign in_grant = (state == GRANT_I) || (state == GRANT_D);
  assign beat     = in_grant && !mem_busy;
  assign stall    = in_grant && mem_busy;

  // Arbitration: a lone requester wins; on a tie the port not served last wins
  always_comb begin
    load   = 1'b0;
    pick_d = 1'b0;
    if (state == IDLE && (i_req || d_req)) begin
      load   = 1'b1;
      pick_d = d_req && (!i_req || !last_d);
    end
  end

  assign start_addr = pick_d ? d_addr : i_addr;
  assign start_len  = burst_len(pick_d ? d_acc_size[1:0] : i_acc_size[1:0]);

  mem_burst_ctr #(
    .ADDRESS_SIZE (ADDRESS_SIZE)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .start_addr (start_addr),
    .len        (start_len),
    .adv        (beat),
    .addr       (cur_addr),
    .last       (last)
  );

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;

  // Trips on the WD_LIMIT-th consecutive stalled grant cycle
  assign wd_trip = stall && (wd_cnt == WD_W'(WD_LIMIT - 1));

  // Count consecutive stall cycles; err stays set until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (stall && !wd_trip) ? wd_cnt + 1'b1 : '0;
      if (wd_trip)
        err <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif

  // Arbiter FSM plus registered read-valid flags for the cycle after each beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      wren_q   <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      i_rvalid <= (state == GRANT_I) && !mem_busy;
      d_rvalid <= (state == GRANT_D) && !mem_busy && !wren_q;
      case (state)
        IDLE: begin
          if (load) begin
            state  <= pick_d ? GRANT_D : GRANT_I;
            last_d <= pick_d;
            wren_q <= pick_d && d_wren;
          end
        end
        GRANT_I, GRANT_D: begin
          if ((beat && last) || wd_trip)
            state <= DRAIN;
        end
        default: state <= IDLE;  // DRAIN is always a single cycle
      endcase
    end
  end

  assign i_beat   = (state == GRANT_I) && !mem_busy;
  assign d_beat   = (state == GRANT_D) && !mem_busy;
  assign i_done   = (state == DRAIN) && !last_d;
  assign d_done   = (state == DRAIN) && last_d;
  assign mem_en   = in_grant;
  assign mem_wren = (state == GRANT_D) && wren_q;
  assign mem_addr = in_grant ? cur_addr : '0;
  assign mem_d_in = mem_wren ? d_wdata : '0;
  assign rdata    = (i_rvalid || d_rvalid) ? mem_d_out : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDRESS_SIZE, default 32, address width; DATA_SIZE, default 32, word width; ACCESS_SIZE, default 2, burst-code width; WD_LIMIT, default 255, watchdog stall limit in cycles.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_req  in  1  instruction-fetch request; held until i_done.
- i_addr  in  ADDRESS_SIZE  fetch start byte address, word-aligned.
- i_acc_size  in  ACCESS_SIZE  fetch burst code.
- i_beat  out  1  fetch beat accepted by memory.
- i_rvalid  out  1  rdata valid for the fetch port.
- i_done  out  1  one-cycle pulse, fetch burst complete.
- d_req  in  1  data-port request; held until d_done.
- d_addr  in  ADDRESS_SIZE  data start byte address, word-aligned.
- d_acc_size  in  ACCESS_SIZE  data burst code.
- d_wren  in  1  1 = store burst, 0 = load burst.
- d_wdata  in  DATA_SIZE  current store word; advances after each d_beat.
- d_beat  out  1  data beat accepted by memory.
- d_rvalid  out  1  rdata valid for the data port.
- d_done  out  1  one-cycle pulse, data burst complete.
- rdata  out  DATA_SIZE  read word, shared by both ports.
- mem_addr  out  ADDRESS_SIZE  memory word address.
- mem_d_in  out  DATA_SIZE  memory write data.
- mem_d_out  in  DATA_SIZE  memory read data, one cycle after acceptance.
- mem_wren  out  1  memory write enable.
- mem_en  out  1  memory access strobe.
- mem_busy  in  1  memory stall; a beat is accepted only when mem_en=1 and mem_busy=0.
- err  out  1  sticky watchdog error.

Function
REQ-004 SHALL implement the FSM IDLE -> GRANT_I or GRANT_D -> DRAIN -> IDLE.
REQ-005 SHALL encode burst codes as 00 = 1 word, 01 = 4 words, 10 = 8 words, 11 = 16 words; the beat counter is 5 bits wide.
REQ-006 SHALL, in IDLE, grant a single pending requester; when both are pending it SHALL grant the port not granted last (round-robin); the first tie after reset SHALL go to the data port.
REQ-007 SHALL latch the start address, burst length and wren of the granted requester at grant; later changes to the request inputs SHALL be ignored until done.
REQ-008 SHALL drive mem_en=1 in every GRANT cycle; mem_addr SHALL be the start address plus 4 times the number of beats already accepted, wrapping modulo 2^ADDRESS_SIZE.
REQ-009 SHALL, on each accepted beat, pulse i_beat or d_beat; for stores, mem_d_in SHALL equal d_wdata in that cycle.
REQ-010 SHALL, for each accepted read beat, drive rdata = mem_d_out and the owning port's rvalid in the next cycle.
REQ-011 SHALL hold mem_addr, mem_wren and mem_en stable while mem_busy=1 (no beat lost or duplicated).
REQ-012 SHALL leave GRANT for DRAIN in the cycle after the last beat is accepted; DRAIN SHALL last exactly one cycle, carry the final rvalid (reads) and pulse done, then return to IDLE.
REQ-013 SHALL use the grant order I, IDLE, I when a new i_req is already pending at that DRAIN and d_req is low; this gives a minimum inter-burst gap of one idle cycle.
REQ-014 SHALL keep mem_en=0 in IDLE and DRAIN.
REQ-015 SHALL ignore a requester that drops its req mid-burst; the burst SHALL complete.

Reset
REQ-016 SHALL, when rst_n=0 at a clock edge, abort any burst, enter IDLE, reset the round-robin pointer to favour the data port, and drive all outputs (including err) to 0 in the following cycle.
REQ-017 SHALL not pulse done for a burst aborted by reset.

Configuration
REQ-018 SHALL, with MEM_ARB_WATCHDOG_EN defined, count consecutive cycles of mem_en=1 and mem_busy=1; when the count reaches WD_LIMIT it SHALL abort the burst, pulse done, set err sticky until reset, and enter DRAIN.
REQ-019 SHALL, without MEM_ARB_WATCHDOG_EN, tie err to 0, include no counter, and wait on mem_busy indefinitely.

Structure
REQ-020 SHALL place the burst-code constants, the burst-length decode function and the FSM state enum in package mem_pkg.
REQ-021 SHALL contain one natural sub-module, mem_burst_ctr, holding the beat counter and address incrementer; arbitration and the FSM stay at top level.

Verification
REQ-022 SHALL pass single fetch: i_req, i_addr=0x100, code 00, mem_busy=0 -> one i_beat, i_rvalid the next cycle, i_done 2 cycles after grant.
REQ-023 SHALL pass store burst: d_req, d_wren=1, d_addr=0x200, code 01 -> mem_addr 0x200, 0x204, 0x208, 0x20C, four d_beats, then d_done.
REQ-024 SHALL pass contention: i_req and d_req asserted together after reset -> D first, then I; repeated together -> D, I alternating.
REQ-025 SHALL pass stall: mem_busy=1 for 3 cycles mid 8-word read -> address held, exactly 8 d_rvalid, no duplicates.
REQ-026 SHALL pass reset mid-burst: rst_n=0 at beat 2 of 16 -> next cycle IDLE, all outputs 0, no d_done.
REQ-027 SHALL pass watchdog (MEM_ARB_WATCHDOG_EN): mem_busy=1 held -> after WD_LIMIT cycles err=1, done pulse, FSM back in IDLE.
